unlock_sequencer: RTL
=====================

UNLOCK_SEQUENCER -- requirements
Module: unlock_sequencer

Interface
REQ-001 SHALL provide parameter CODE_LEN, default 11, the number of code bits serialized per attempt.
REQ-002 SHALL provide parameter MAX_FAIL, default 3, the number of consecutive failures that causes a permanent lock.
REQ-003 SHALL provide parameter LOCK_CYCLES, default 256, the base lockout duration in clk cycles.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port code_valid  input  1  code word offered.
REQ-007 SHALL have port code_ready  output  1  sequencer accepts a code word.
REQ-008 SHALL have port code_data  input  CODE_LEN  code word, MSB sent first.
REQ-009 SHALL have port det_rst  output  1  reset strobe to the sequence detector.
REQ-010 SHALL have port det_in  output  1  serial bit to the detector.
REQ-011 SHALL have port det_out  input  1  detector match output; combinational on det_in.
REQ-012 SHALL have port grant  output  1  one-cycle pulse when the code matched.
REQ-013 SHALL have port fail  output  1  one-cycle pulse when the code did not match.
REQ-014 SHALL have port locked  output  1  high while the lockout timer runs.
REQ-015 SHALL have port perm_lock  output  1  permanent lock; sticky until rst.
REQ-016 SHALL have port fail_cnt  output  $clog2(MAX_FAIL+1)  count of consecutive failures.

Function
REQ-017 SHALL implement states IDLE, CLEAR, SHIFT, RESULT, LOCKOUT and PERM.
REQ-018 SHALL drive code_ready=1 only in IDLE.
REQ-019 In IDLE, when code_valid&&code_ready, SHALL capture code_data into the shift register and move to CLEAR.
REQ-020 In CLEAR, SHALL drive det_rst=1 for exactly one cycle, load the bit counter with CODE_LEN-1, and move to SHIFT.
REQ-021 In SHIFT, SHALL drive det_in equal to the shift register MSB, shift left once per cycle, and decrement the counter; SHIFT SHALL last exactly CODE_LEN cycles.
REQ-022 SHALL sample det_out only in the SHIFT cycle where the counter equals 0; match=det_out at that cycle, and det_out SHALL be ignored in every other cycle.
REQ-023 SHALL drive det_in=0 in every state except SHIFT.
REQ-024 In RESULT, SHALL pulse grant if match, otherwise pulse fail, for exactly one cycle; the two pulses SHALL never be high together.
REQ-025 Latency: for a handshake at cycle T, CLEAR SHALL be at T+1, SHIFT at T+2..T+1+CODE_LEN, and the grant/fail pulse at T+2+CODE_LEN.
REQ-026 On grant, SHALL clear fail_cnt to 0 and return to IDLE.
REQ-027 On fail, SHALL increment fail_cnt (saturating at MAX_FAIL); if the new value equals MAX_FAIL, SHALL go to PERM, otherwise to LOCKOUT.
REQ-028 On entry to LOCKOUT, SHALL load the timer with LOCK_CYCLES << (fail_cnt_new-1), sized without overflow for fail_cnt_new=MAX_FAIL-1; locked=1 SHALL hold for exactly that many cycles, after which the block returns to IDLE.
REQ-029 PERM SHALL be terminal: perm_lock=1, code_ready=0, det_rst held at 1; only rst SHALL exit PERM.
REQ-030 SHALL ignore code_valid in every state other than IDLE; code_data SHALL not be re-sampled after capture.
REQ-031 SHALL not let fail_cnt wrap; MAX_FAIL=1 SHALL go to PERM on the first failure.

Reset
REQ-032 On rst, SHALL asynchronously enter IDLE with code_ready=1 after release, det_rst=0, det_in=0, grant=0, fail=0, locked=0, perm_lock=0, fail_cnt=0, and the timer and shift register cleared.
REQ-033 On rst mid-SHIFT or mid-LOCKOUT, SHALL abort with no grant/fail pulse and no fail_cnt update.

Verification
REQ-034 Correct code: bench uses the detector model and sends code_data=11'h094 (00010010100) -> det_rst pulse at T+1, 11 serial bits, grant=1 at T+13, fail_cnt=0.
REQ-035 Wrong code: send 11'h000 -> fail=1 at T+13, fail_cnt=1, locked=1 for exactly 256 cycles, code_ready=0 throughout, then code_ready=1.
REQ-036 Backoff and permanent lock: three consecutive wrong codes -> lockouts of 256 then 512 cycles, then perm_lock=1 with fail_cnt=3; a later 11'h094 is not accepted.
REQ-037 Recovery: one wrong code then 11'h094 -> grant=1 and fail_cnt returns from 1 to 0.
REQ-038 Protocol: code_valid held high during SHIFT and LOCKOUT -> no extra capture; det_out forced to 1 before the last bit -> not treated as a match.
REQ-039 Reset: rst at the 5th SHIFT cycle, and separately rst in PERM -> all outputs take their REQ-032 values, with no grant or fail pulse.

Source files
------------

// File: rtl/unlock_sequencer.sv
// unlock_sequencer: serializes a captured code word into an external sequence
// detector, samples the detector's match on the last bit, and grants or fails
// the attempt. Consecutive failures trigger an exponentially growing lockout
// and, after MAX_FAIL failures, a permanent lock that only rst clears.
module unlock_sequencer #(
   parameter int CODE_LEN    = 11,
   parameter int MAX_FAIL    = 3,
   parameter int LOCK_CYCLES = 256
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        code_valid,
   output logic                        code_ready,
   input  logic [CODE_LEN-1:0]         code_data,
   output logic                        det_rst,
   output logic                        det_in,
   input  logic                        det_out,
   output logic                        grant,
   output logic                        fail,
   output logic                        locked,
   output logic                        perm_lock,
   output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt
);

   localparam int FCW = $clog2(MAX_FAIL+1);
   localparam int CW  = $clog2(CODE_LEN+1);
   // Wide enough for LOCK_CYCLES << (MAX_FAIL-2), the longest lockout.
   localparam int TW  = $clog2(LOCK_CYCLES+1) + MAX_FAIL;

   typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, RESULT, LOCKOUT, PERM} state_t;

   state_t              state;
   logic [CODE_LEN-1:0] sreg;
   logic [CW-1:0]       cnt;
   logic [TW-1:0]       timer;
   logic [FCW-1:0]      fail_inc;

   // Saturating increment so fail_cnt can never wrap.
   assign fail_inc = (fail_cnt == FCW'(MAX_FAIL)) ? fail_cnt : fail_cnt + 1'b1;

   // Sequencer FSM; every output is a register updated alongside the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         sreg       <= '0;
         cnt        <= '0;
         timer      <= '0;
         code_ready <= 1'b1;
         det_rst    <= 1'b0;
         det_in     <= 1'b0;
         grant      <= 1'b0;
         fail       <= 1'b0;
         locked     <= 1'b0;
         perm_lock  <= 1'b0;
         fail_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (code_valid) begin
                  sreg       <= code_data;
                  code_ready <= 1'b0;
                  det_rst    <= 1'b1;
                  state      <= CLEAR;
               end
            end
            CLEAR: begin
               // Detector is reset this cycle; first bit appears next cycle.
               det_rst <= 1'b0;
               cnt     <= CW'(CODE_LEN-1);
               det_in  <= sreg[CODE_LEN-1];
               sreg    <= sreg << 1;
               state   <= SHIFT;
            end
            SHIFT: begin
               if (cnt == '0) begin
                  // Last bit is on det_in now: this is the only cycle det_out counts.
                  det_in <= 1'b0;
                  state  <= RESULT;
                  if (det_out) begin
                     grant    <= 1'b1;
                     fail_cnt <= '0;
                  end else begin
                     fail     <= 1'b1;
                     fail_cnt <= fail_inc;
                  end
               end else begin
                  det_in <= sreg[CODE_LEN-1];
                  sreg   <= sreg << 1;
                  cnt    <= cnt - 1'b1;
               end
            end
            RESULT: begin
               grant <= 1'b0;
               fail  <= 1'b0;
               if (grant) begin
                  code_ready <= 1'b1;
                  state      <= IDLE;
               end else if (fail_cnt == FCW'(MAX_FAIL)) begin
                  perm_lock <= 1'b1;
                  det_rst   <= 1'b1;
                  state     <= PERM;
               end else begin
                  // Lockout doubles with each consecutive failure; timer counts N-1..0.
                  locked <= 1'b1;
                  timer  <= (TW'(LOCK_CYCLES) << (fail_cnt - 1'b1)) - 1'b1;
                  state  <= LOCKOUT;
               end
            end
            LOCKOUT: begin
               if (timer == '0) begin
                  locked     <= 1'b0;
                  code_ready <= 1'b1;
                  state      <= IDLE;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            PERM: begin
               state <= PERM;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
